exe_mem_elastic_reg: RTL
========================

Name: exe_mem_elastic_reg

Overview:
- Parametrised successor to the EXE→MEM pipeline register. It carries the WB/MEM control enables, the ALU result, the store value and the destination register.
- Adds a valid/ready handshake, a 2-entry skid buffer (so back-pressure from MEM never drops an EXE result), a synchronous flush for branch/exception squash, and a saturating stall-cycle counter.
- Sits between the EXE stage and the MEM stage.

Parameters:
- DATA_W, 32, width of ALU_result and ST_val.
- DEST_W, 5, width of Dest (register index).
- CNT_W, 16, width of stall_cnt.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  squash all held entries (sync).
- in_valid  in  1  EXE presents a valid result.
- in_ready  out  1  stage can accept this cycle.
- WB_en_in  in  1  write-back enable.
- MEM_R_EN_in  in  1  memory read enable.
- MEM_W_EN_in  in  1  memory write enable.
- ALU_result_in  in  DATA_W  ALU result / address.
- ST_val_in  in  DATA_W  store data.
- Dest_in  in  DEST_W  destination register.
- out_valid  out  1  MEM side holds a valid entry.
- out_ready  in  1  MEM consumes this cycle.
- WB_en, MEM_R_EN, MEM_W_EN  out  1 each  control to MEM; forced 0 when out_valid=0.
- ALU_result, ST_val  out  DATA_W  payload from main register.
- Dest  out  DEST_W  payload from main register.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0; saturating.

Behaviour:
- Storage: main register (drives outputs) and skid register, each with its own valid bit. All state updates on posedge clk only.
- Handshake: accept = in_valid & in_ready; consume = out_valid & out_ready. in_ready is registered and equals !skid_valid.
- States:
  - EMPTY (main invalid).
  - ONE (main valid, skid invalid).
  - FULL (both valid).
- Transitions:
  - EMPTY: accept → ONE; main ← inputs.
  - ONE: accept & consume → ONE; main ← inputs. accept only → FULL; skid ← inputs. consume only → EMPTY.
  - FULL: in_ready=0, so no accept. consume → ONE; main ← skid; skid invalid.
- Latency: an entry accepted in EMPTY appears on outputs with out_valid=1 in the next cycle. Throughput is 1 per cycle while out_ready=1.
- Ordering: strict FIFO. Skid contents always exit before any later entry.
- Flush (priority over accept/consume, below rst):
  - Next cycle: both valid bits 0, state EMPTY, in_ready=1.
  - Any entry offered in the flush cycle is discarded.
  - Payload registers may hold stale data, but control outputs read 0 via gating.
  - stall_cnt is unaffected.
- Reset (rst=1 at a clock edge, including mid-transfer):
  - out_valid=0, in_ready=1.
  - WB_en=MEM_R_EN=MEM_W_EN=0; ALU_result=0, ST_val=0, Dest=0; stall_cnt=0.
  - Skid contents cleared.
- stall_cnt: +1 each cycle with out_valid & !out_ready; holds at 2^CNT_W-1; never wraps. Cleared only by rst.
- Bubble: whenever out_valid=0, the control enables are forced 0, so no spurious write-back or memory access occurs.
- Inputs are ignored when in_valid=0. in_valid may deassert without penalty.

Test Plan:
- Reset then stream: rst 1 cycle; in_valid=1, out_ready=1, ALU_result_in=0x10,0x20,0x30 on consecutive cycles → outputs 0x10,0x20,0x30 one cycle later each; in_ready stays 1; stall_cnt=0.
- Back-pressure/skid: out_ready=0 and send A=0x11 then B=0x22 → FULL, in_ready=0 after the second accept, C held off. Raise out_ready → A, then B, then C in order; none lost or duplicated. stall_cnt equals the number of stalled cycles.
- Flush in FULL: fill with A,B; assert flush with in_valid=1 (C=0x33) → next cycle out_valid=0, WB_en=MEM_W_EN=0, in_ready=1. C never appears at the output.
- Simultaneous accept+consume in ONE: main=A, in_valid=1 with B, out_ready=1 → next cycle output B, state ONE, skid never used.
- Mid-operation reset: FULL with MEM_W_EN=1 entries, assert rst → next cycle all outputs 0, stall_cnt=0, in_ready=1. After reset, new entry D passes with 1-cycle latency.
- Saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles → stall_cnt reaches 15 and holds.

Source files
------------

// File: rtl/exe_mem_elastic_reg.sv
// EXE->MEM elastic pipeline register: valid/ready handshake, 2-entry skid,
// synchronous flush and a saturating stall-cycle counter.
module exe_mem_elastic_reg #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              WB_en_in,
  input  logic              MEM_R_EN_in,
  input  logic              MEM_W_EN_in,
  input  logic [DATA_W-1:0] ALU_result_in,
  input  logic [DATA_W-1:0] ST_val_in,
  input  logic [DEST_W-1:0] Dest_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              WB_en,
  output logic              MEM_R_EN,
  output logic              MEM_W_EN,
  output logic [DATA_W-1:0] ALU_result,
  output logic [DATA_W-1:0] ST_val,
  output logic [DEST_W-1:0] Dest,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic              wb;
    logic              rd;
    logic              wr;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] st;
    logic [DEST_W-1:0] dest;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t state, state_nxt;
  entry_t main_q, skid_q, main_d, skid_d, in_e;
  logic   accept, consume;

  assign in_e = {WB_en_in, MEM_R_EN_in, MEM_W_EN_in, ALU_result_in, ST_val_in, Dest_in};

  // Both valid bits are encoded in the state register, so in_ready is a flop output.
  assign out_valid = (state != EMPTY);
  assign in_ready  = (state != FULL);
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state  <= state_nxt;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  always_comb begin
    state_nxt = state;
    main_d    = main_q;
    skid_d    = skid_q;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          state_nxt = ONE;
          main_d    = in_e;
        end
        ONE: begin
          if (accept && consume) begin
            main_d = in_e;
          end else if (accept) begin
            state_nxt = FULL;
            skid_d    = in_e;
          end else if (consume) begin
            state_nxt = EMPTY;
          end
        end
        FULL: if (consume) begin
          state_nxt = ONE;
          main_d    = skid_q;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != {CNT_W{1'b1}})
      stall_cnt <= stall_cnt + 1'b1;
  end

  // Gate controls so a bubble can never cause a write-back or memory access.
  assign WB_en      = out_valid & main_q.wb;
  assign MEM_R_EN   = out_valid & main_q.rd;
  assign MEM_W_EN   = out_valid & main_q.wr;
  assign ALU_result = main_q.alu;
  assign ST_val     = main_q.st;
  assign Dest       = main_q.dest;

endmodule
